// File: rtl/kp_pkg.sv
// Shared definitions for the 3x3 window generator: pixel and window-row
// widths, FSM state encoding, and a helper that packs one window row.
// Used by kp_window_gen (optional feature macro: KP_WINDOW_FRAME_CNT_EN)
// and kp_linebuf.
package kp_pkg;

  localparam int KP_PIX_W  = 8;
  localparam int KP_WROW_W = 24;

  typedef enum logic [1:0] {
    KP_ST_IDLE   = 2'd0,
    KP_ST_FILL   = 2'd1,
    KP_ST_ACTIVE = 2'd2
  } kp_state_e;

  // Pack two older pixels and the newest one into a window row;
  // the oldest pixel (left column) lands in the top byte.
  function automatic logic [KP_WROW_W-1:0] kp_win_row(
    input logic [2*KP_PIX_W-1:0] hist,
    input logic [KP_PIX_W-1:0]   newest
  );
    return {hist, newest};
  endfunction

endpackage

// File: rtl/kp_linebuf.sv
// Single line buffer: DEPTH x 8-bit, combinational read, synchronous write.
// A read and a write to the same address in one cycle returns the old
// contents (read-before-write). Contents are deliberately not reset.
module kp_linebuf
  import kp_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [KP_PIX_W-1:0] i_wdata,
  output logic [KP_PIX_W-1:0] o_rdata
);

  logic [KP_PIX_W-1:0] mem_r [DEPTH];

  assign o_rdata = mem_r[i_addr];

  // Store the incoming pixel at the addressed column.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/kp_window_gen.sv
// 3x3 sliding-window generator for a raster greyscale stream.
// Two line buffers hold the previous two lines; three 2-pixel history
// registers plus the registered output form the 3-tap row shifters.
// A window is emitted one cycle after each accepted pixel with row>=2 and
// col>=2 once the frame has filled its first two lines.
// Optional feature: define KP_WINDOW_FRAME_CNT_EN to add o_frame_cnt,
// a 16-bit count of completed frames.
module kp_window_gen
  import kp_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [KP_PIX_W-1:0]  i_data,
  input  logic                 i_valid,
  input  logic                 i_sof,
  output logic [KP_WROW_W-1:0] o_r0_data,
  output logic [KP_WROW_W-1:0] o_r1_data,
  output logic [KP_WROW_W-1:0] o_r2_data,
  output logic                 o_valid
`ifdef KP_WINDOW_FRAME_CNT_EN
  ,
  output logic [15:0]          o_frame_cnt
`endif
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  kp_state_e state_r;
  kp_state_e state_nxt_s;

  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] cur_col_s;
  logic [ROW_W-1:0] cur_row_s;

  logic accept_s;
  logic fire_s;
  logic last_pix_s;
  logic enter_active_s;

  logic [KP_PIX_W-1:0] lb0_rd_s;
  logic [KP_PIX_W-1:0] lb1_rd_s;

  // Two most recent pixels of each window row; the third tap is the output register.
  logic [2*KP_PIX_W-1:0] top_hist_r;
  logic [2*KP_PIX_W-1:0] mid_hist_r;
  logic [2*KP_PIX_W-1:0] bot_hist_r;

  // Position of the pixel on the bus: a start-of-frame pixel is always (0,0).
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    if (i_valid && i_sof) begin
      cur_col_s = '0;
      cur_row_s = '0;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r <= KP_ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: sof restarts the frame from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (i_valid && i_sof) begin
      state_nxt_s = KP_ST_FILL;
    end else begin
      case (state_r)
        KP_ST_IDLE: begin
          state_nxt_s = KP_ST_IDLE;
        end
        KP_ST_FILL: begin
          if (enter_active_s) begin
            state_nxt_s = KP_ST_ACTIVE;
          end else begin
            state_nxt_s = KP_ST_FILL;
          end
        end
        KP_ST_ACTIVE: begin
          if (last_pix_s) begin
            state_nxt_s = KP_ST_FILL;
          end else begin
            state_nxt_s = KP_ST_ACTIVE;
          end
        end
        default: begin
          state_nxt_s = KP_ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: pixel acceptance, window strobe, frame-end and fill-done flags.
  always_comb begin
    accept_s       = 1'b0;
    fire_s         = 1'b0;
    last_pix_s     = 1'b0;
    enter_active_s = 1'b0;
    if (i_rstn && i_valid && (i_sof || (state_r != KP_ST_IDLE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    fire_s         = accept_s && (state_r == KP_ST_ACTIVE) && !i_sof &&
                     (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
    last_pix_s     = accept_s && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    enter_active_s = accept_s && (cur_row_s == ROW_TWO) && (cur_col_s == '0);
  end

  // Raster position counters, advanced on every accepted pixel.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (cur_col_s == COL_LAST) begin
        col_r <= '0;
        if (cur_row_s == ROW_LAST) begin
          row_r <= '0;
        end else begin
          row_r <= cur_row_s + ROW_W'(1);
        end
      end else begin
        col_r <= cur_col_s + COL_W'(1);
        row_r <= cur_row_s;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Newest previous line: takes the incoming pixel.
  kp_linebuf #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_lb0 (
    .i_clk   (i_clk),
    .i_we    (accept_s),
    .i_addr  (cur_col_s),
    .i_wdata (i_data),
    .o_rdata (lb0_rd_s)
  );

  // Oldest previous line: takes what lb0 held at this column.
  kp_linebuf #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (accept_s),
    .i_addr  (cur_col_s),
    .i_wdata (lb0_rd_s),
    .o_rdata (lb1_rd_s)
  );

  // Row history shift: each row keeps its two most recent column pixels.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      top_hist_r <= '0;
      mid_hist_r <= '0;
      bot_hist_r <= '0;
    end else if (accept_s) begin
      top_hist_r <= {top_hist_r[KP_PIX_W-1:0], lb1_rd_s};
      mid_hist_r <= {mid_hist_r[KP_PIX_W-1:0], lb0_rd_s};
      bot_hist_r <= {bot_hist_r[KP_PIX_W-1:0], i_data};
    end else begin
      top_hist_r <= top_hist_r;
      mid_hist_r <= mid_hist_r;
      bot_hist_r <= bot_hist_r;
    end
  end

  // Registered window output; data holds between strobes.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid   <= 1'b0;
      o_r0_data <= '0;
      o_r1_data <= '0;
      o_r2_data <= '0;
    end else begin
      o_valid <= fire_s;
      if (fire_s) begin
        o_r0_data <= kp_win_row(top_hist_r, lb1_rd_s);
        o_r1_data <= kp_win_row(mid_hist_r, lb0_rd_s);
        o_r2_data <= kp_win_row(bot_hist_r, i_data);
      end else begin
        o_r0_data <= o_r0_data;
        o_r1_data <= o_r1_data;
        o_r2_data <= o_r2_data;
      end
    end
  end

`ifdef KP_WINDOW_FRAME_CNT_EN
  // Completed-frame counter: bumps on the last pixel of a frame, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_frame_cnt <= 16'h0000;
    end else if (last_pix_s) begin
      o_frame_cnt <= o_frame_cnt + 16'h0001;
    end else begin
      o_frame_cnt <= o_frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_kp_window_gen.sv
// Testbench for kp_window_gen with a 5x4 image. A frame-array model
// predicts each window; a compare process checks every cycle and literal
// expectations pin first/last windows and window counts per scenario.
module tb_kp_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk;
  logic        rstn;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_sof;
  logic [23:0] o_r0_data;
  logic [23:0] o_r1_data;
  logic [23:0] o_r2_data;
  logic        o_valid;
`ifdef KP_WINDOW_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  int tests = 0;
  int fails = 0;

  kp_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_sof     (i_sof),
    .o_r0_data (o_r0_data),
    .o_r1_data (o_r1_data),
    .o_r2_data (o_r2_data),
    .o_valid   (o_valid)
`ifdef KP_WINDOW_FRAME_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  pix [H][W];
  bit          m_in_frame = 1'b0;
  int          m_row = 0;
  int          m_col = 0;
  bit          m_ready = 1'b0;
  logic        m_valid = 1'b0;
  logic [23:0] m_r0 = '0;
  logic [23:0] m_r1 = '0;
  logic [23:0] m_r2 = '0;
  int          m_fcnt = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_in_frame = 1'b0;
      m_row = 0;
      m_col = 0;
      m_valid = 1'b0;
      m_r0 = '0;
      m_r1 = '0;
      m_r2 = '0;
      m_fcnt = 0;
      m_ready = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (i_valid && (i_sof || m_in_frame)) begin
        if (i_sof) begin
          m_in_frame = 1'b1;
          m_row = 0;
          m_col = 0;
        end
        pix[m_row][m_col] = i_data;
        if (m_row >= 2 && m_col >= 2) begin
          m_valid = 1'b1;
          m_r0 = {pix[m_row-2][m_col-2], pix[m_row-2][m_col-1], pix[m_row-2][m_col]};
          m_r1 = {pix[m_row-1][m_col-2], pix[m_row-1][m_col-1], pix[m_row-1][m_col]};
          m_r2 = {pix[m_row][m_col-2],   pix[m_row][m_col-1],   pix[m_row][m_col]};
        end
        if (m_row == H-1 && m_col == W-1) m_fcnt = (m_fcnt + 1) % 65536;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row + 1) % H;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [71:0] wq [$];

  always @(negedge clk) begin
    if (m_ready) begin
      chk("o_valid",   72'(o_valid),   72'(m_valid));
      chk("o_r0_data", 72'(o_r0_data), 72'(m_r0));
      chk("o_r1_data", 72'(o_r1_data), 72'(m_r1));
      chk("o_r2_data", 72'(o_r2_data), 72'(m_r2));
`ifdef KP_WINDOW_FRAME_CNT_EN
      chk("o_frame_cnt", 72'(o_frame_cnt), 72'(m_fcnt));
`endif
      if (o_valid) wq.push_back({o_r0_data, o_r1_data, o_r2_data});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_pix(input logic [7:0] d, input logic s, input logic v);
    @(negedge clk);
    i_data  = d;
    i_sof   = s;
    i_valid = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_pix(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pix(8'(r*16 + c), (r == 0 && c == 0), 1'b1);
        if (gaps) send_pix(8'h00, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic check_frame(input string name, input int base);
    chk({name, "_count"}, 72'(wq.size() - base), 72'd6);
    if (wq.size() - base >= 6) begin
      chk({name, "_first"}, wq[base],   {24'h000102, 24'h101112, 24'h202122});
      chk({name, "_last"},  wq[base+5], {24'h121314, 24'h222324, 24'h323334});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int base;
    rstn    = 1'b0;
    i_data  = 8'h00;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("reset_valid", 72'(o_valid), 72'd0);
    chk("reset_r0",    72'(o_r0_data), 72'd0);

    // Pixels before any sof are dropped
    base = wq.size();
    for (int k = 0; k < 10; k++) send_pix(8'(8'hA0 + k), 1'b0, 1'b1);
    idle(3);
    chk("nosof_count", 72'(wq.size() - base), 72'd0);

    // Contiguous frame
    base = wq.size();
    send_frame(1'b0);
    idle(3);
    check_frame("contig", base);

    // Every other cycle valid
    base = wq.size();
    send_frame(1'b1);
    idle(3);
    check_frame("gapped", base);

    // sof reasserted at pixel (1,3)
    base = wq.size();
    for (int k = 0; k < W + 3; k++) send_pix(8'((k / W) * 16 + (k % W)), (k == 0), 1'b1);
    send_frame(1'b0);
    idle(3);
    check_frame("resof", base);

    // Reset at pixel (3,2)
    base = wq.size();
    begin : rst_mid
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (r == 3 && c == 2) begin
            @(negedge clk);
            rstn    = 1'b0;
            i_data  = 8'h32;
            i_sof   = 1'b0;
            i_valid = 1'b1;
            @(negedge clk);
            rstn    = 1'b1;
            i_valid = 1'b0;
            chk("midrst_valid", 72'(o_valid),   72'd0);
            chk("midrst_r0",    72'(o_r0_data), 72'd0);
            chk("midrst_r1",    72'(o_r1_data), 72'd0);
            chk("midrst_r2",    72'(o_r2_data), 72'd0);
            disable rst_mid;
          end
          send_pix(8'(r*16 + c), (r == 0 && c == 0), 1'b1);
        end
      end
    end
    chk("midrst_windows_before", 72'(wq.size() - base), 72'd3);
    // After reset the block must be idle: pixels without sof do nothing
    base = wq.size();
    for (int k = 0; k < 12; k++) send_pix(8'(8'h50 + k), 1'b0, 1'b1);
    idle(2);
    chk("postrst_idle_count", 72'(wq.size() - base), 72'd0);
    base = wq.size();
    send_frame(1'b0);
    idle(3);
    check_frame("postrst", base);

`ifdef KP_WINDOW_FRAME_CNT_EN
    do_reset();
    chk("fcnt_reset", 72'(o_frame_cnt), 72'd0);
    send_frame(1'b0);
    for (int k = 0; k < 7; k++) send_pix(8'((k / W) * 16 + (k % W)), (k == 0), 1'b1);
    send_frame(1'b0);
    idle(3);
    chk("fcnt_two", 72'(o_frame_cnt), 72'd2);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
